// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-target slice: FSM encoding, the
// ADXL345 bus address and the register map offsets it exposes.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_e;

    localparam logic [6:0] ADXL345_ADDR = 7'h53;

    localparam logic [7:0] REG_BW_RATE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_DATAX0      = 8'h32;
    localparam logic [7:0] REG_DATAX1      = 8'h33;
    localparam logic [7:0] REG_DATAY0      = 8'h34;
    localparam logic [7:0] REG_DATAY1      = 8'h35;
    localparam logic [7:0] REG_DATAZ0      = 8'h36;
    localparam logic [7:0] REG_DATAZ1      = 8'h37;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags START, STOP and SCL edges,
// all derived from the synchronized levels only.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    // NOTE: the flops reset to 1 (idle bus level) so leaving reset never
    // looks like an SDA or SCL falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign o_sda      = r_sda_sync;
    assign o_scl_rise = r_scl_sync & ~r_scl_prev;
    assign o_scl_fall = ~r_scl_sync & r_scl_prev;
    assign o_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign o_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an external register file: pointer byte, auto-incrementing
// burst writes and burst reads. No clock stretching.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = ADXL345_ADDR,
    parameter int         REG_AW      = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    input  logic [7:0]        reg_rdata,
    output logic              reg_re,
    output logic              busy
);

    localparam logic [REG_AW-1:0] ADDR_ONE = 1;

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    i2c_state_e        r_state, w_state;
    logic [3:0]        r_bit_cnt, w_bit_cnt;
    logic [7:0]        r_shift, w_shift;
    logic [7:0]        r_tx, w_tx;
    logic              r_sda_oe, w_sda_oe;
    logic [REG_AW-1:0] r_reg_addr, w_reg_addr;
    logic [7:0]        r_reg_wdata, w_reg_wdata;
    logic              r_we, w_we, r_re, w_re;
    logic              r_busy, w_busy, r_rw, w_rw;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte = {r_shift[6:0], w_sda};

    // NOTE: every next-value gets a default first, so no path leaves a latch.
    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_shift     = r_shift;
        w_tx        = r_tx;
        w_sda_oe    = r_sda_oe;
        w_reg_addr  = r_reg_addr;
        w_reg_wdata = r_reg_wdata;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_busy      = r_busy;
        w_rw        = r_rw;

        if (w_stop) begin
            w_state   = ST_IDLE;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
            w_bit_cnt = 4'd0;
        end else if (w_start) begin
            w_state   = ST_ADDR;
            w_sda_oe  = 1'b0;
            w_bit_cnt = 4'd0;
        end else if (w_scl_rise) begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    w_shift   = w_byte;
                    w_bit_cnt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        if (r_state == ST_ADDR) begin
                            if (w_byte[7:1] == TARGET_ADDR) begin
                                w_state = ST_ADDR_ACK;
                                w_busy  = 1'b1;
                                w_rw    = w_byte[0];
                            end else begin
                                w_state = ST_IDLE;
                            end
                        end else if (r_state == ST_PTR) begin
                            w_reg_addr = w_byte[REG_AW-1:0];
                            w_state    = ST_PTR_ACK;
                        end else begin
                            w_reg_wdata = w_byte;
                            w_we        = 1'b1;
                            w_state     = ST_WDATA_ACK;
                        end
                    end
                end
                ST_RDATA: w_bit_cnt = r_bit_cnt + 4'd1;
                ST_RDATA_ACK: begin
                    // Advance the pointer on the master's ACK so reg_rdata has
                    // settled by the SCL fall that captures the next byte.
                    if (r_bit_cnt == 4'd8) begin
                        w_bit_cnt  = 4'd9;
                        w_shift[0] = w_sda;
                        if (!w_sda) w_reg_addr = r_reg_addr + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end else if (w_scl_fall) begin
            case (r_state)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (!r_sda_oe) begin
                        w_sda_oe = 1'b1;
                    end else begin
                        w_sda_oe  = 1'b0;
                        w_bit_cnt = 4'd0;
                        if (r_state == ST_ADDR_ACK) begin
                            if (r_rw) begin
                                w_tx     = reg_rdata;
                                w_re     = 1'b1;
                                w_sda_oe = ~reg_rdata[7];
                                w_state  = ST_RDATA;
                            end else begin
                                w_state = ST_PTR;
                            end
                        end else if (r_state == ST_PTR_ACK) begin
                            w_state = ST_WDATA;
                        end else begin
                            w_reg_addr = r_reg_addr + ADDR_ONE;
                            w_state    = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (r_bit_cnt == 4'd8) begin
                        w_sda_oe = 1'b0;
                        w_state  = ST_RDATA_ACK;
                    end else if (r_bit_cnt != 4'd0) begin
                        w_tx     = {r_tx[6:0], 1'b0};
                        w_sda_oe = ~r_tx[6];
                    end
                end
                ST_RDATA_ACK: begin
                    if (r_bit_cnt == 4'd9 && !r_shift[0]) begin
                        w_tx      = reg_rdata;
                        w_re      = 1'b1;
                        w_sda_oe  = ~reg_rdata[7];
                        w_bit_cnt = 4'd0;
                        w_state   = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // updates from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_tx        <= 8'd0;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'd0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_busy      <= 1'b0;
            r_rw        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bit_cnt   <= w_bit_cnt;
            r_shift     <= w_shift;
            r_tx        <= w_tx;
            r_sda_oe    <= w_sda_oe;
            r_reg_addr  <= w_reg_addr;
            r_reg_wdata <= w_reg_wdata;
            r_we        <= w_we;
            r_re        <= w_re;
            r_busy      <= w_busy;
            r_rw        <= w_rw;
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs, checked against a
// transaction-level register model.
module tb_i2c_target_regs;

    localparam int Q  = 8;   // clk cycles per quarter SCL period
    localparam int AW = 6;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_line;
    logic          sda_oe, reg_we, reg_re, busy;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata, reg_rdata;

    logic [7:0] rf  [64];   // external register file the DUT talks to
    logic [7:0] mdl [64];   // expected register contents
    wr_t        we_q[$];
    logic [7:0] re_q[$];
    int         n_checks = 0;
    int         n_pass = 0;

    always #10 clk = ~clk;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = rf[reg_addr];

    i2c_target_regs #(.TARGET_ADDR(7'h53), .REG_AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .reg_re    (reg_re),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (reg_we) begin
            rf[reg_addr] <= reg_wdata;
            we_q.push_back('{addr: 8'(reg_addr), data: reg_wdata});
        end
        if (reg_re) re_q.push_back(8'(reg_addr));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q_wait();
        scl_m = 1'b1; q_wait();
        sda_m = 1'b0; q_wait();
        scl_m = 1'b0; q_wait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q_wait();
        scl_m = 1'b1; q_wait();
        sda_m = 1'b1; q_wait();
        q_wait();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    q_wait();
        scl_m = 1'b1; q_wait(); q_wait();
        scl_m = 1'b0; q_wait();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; q_wait();
        scl_m = 1'b1; q_wait();
        b = sda_line; q_wait();
        scl_m = 1'b0; q_wait();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // Write n bytes (data packed LSB byte first) starting at register ptr.
    task automatic do_write(input logic [7:0] ptr, input int n, input logic [31:0] data,
                            input string tag);
        logic ack;
        int   a;
        wr_t  exp_q[$];
        we_q.delete();
        re_q.delete();
        bus_start();
        send_byte(8'hA6, ack);
        check({tag, " addr_ack"}, 32'(ack), 0);
        check({tag, " busy"}, 32'(busy), 1);
        send_byte(ptr, ack);
        check({tag, " ptr_ack"}, 32'(ack), 0);
        for (int i = 0; i < n; i++) begin
            a = (int'(ptr) + i) % 64;
            send_byte(data[8*i +: 8], ack);
            check({tag, " data_ack"}, 32'(ack), 0);
            mdl[a] = data[8*i +: 8];
            exp_q.push_back('{addr: 8'(a), data: data[8*i +: 8]});
        end
        bus_stop();
        check({tag, " busy_after_stop"}, 32'(busy), 0);
        check({tag, " we_count"}, we_q.size(), n);
        for (int i = 0; i < n && i < we_q.size(); i++) begin
            check({tag, " we_addr"}, 32'(we_q[i].addr), 32'(exp_q[i].addr));
            check({tag, " we_data"}, 32'(we_q[i].data), 32'(exp_q[i].data));
        end
        check({tag, " ptr_end"}, 32'(reg_addr), (int'(ptr) + n) % 64);
    endtask

    // Set the pointer, repeated START, then read n bytes (ACK all but the last).
    task automatic do_read(input logic [7:0] ptr, input int n, input string tag);
        logic       ack;
        logic [7:0] d;
        int         a;
        we_q.delete();
        re_q.delete();
        bus_start();
        send_byte(8'hA6, ack);
        check({tag, " waddr_ack"}, 32'(ack), 0);
        send_byte(ptr, ack);
        check({tag, " ptr_ack"}, 32'(ack), 0);
        bus_start();
        send_byte(8'hA7, ack);
        check({tag, " raddr_ack"}, 32'(ack), 0);
        for (int i = 0; i < n; i++) begin
            a = (int'(ptr) + i) % 64;
            recv_byte(i == n - 1, d);
            check({tag, " rdata"}, 32'(d), 32'(mdl[a]));
        end
        bus_stop();
        check({tag, " re_count"}, re_q.size(), n);
        for (int i = 0; i < n && i < re_q.size(); i++)
            check({tag, " re_addr"}, 32'(re_q[i]), (int'(ptr) + i) % 64);
        check({tag, " ptr_end"}, 32'(reg_addr), (int'(ptr) + n - 1) % 64);
        check({tag, " no_we"}, we_q.size(), 0);
        check({tag, " busy_after_stop"}, 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack, b;
        logic [7:0] v;

        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            rf[i]  = v;
            mdl[i] = v;
        end
        rf[16]  = 8'hE5;   // bit 4 (the 4th bit sent) is 0, so SDA is driven low
        mdl[16] = 8'hE5;

        repeat (5) @(negedge clk);
        check("rst sda_oe", 32'(sda_oe), 0);
        check("rst reg_addr", 32'(reg_addr), 0);
        check("rst reg_wdata", 32'(reg_wdata), 0);
        check("rst reg_we", 32'(reg_we), 0);
        check("rst reg_re", 32'(reg_re), 0);
        check("rst busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        do_write(8'h2D, 1, 32'h08, "wr_power_ctl");
        do_read(8'h32, 6, "rd_burst6");

        // Foreign address and general call must both be ignored.
        we_q.delete();
        re_q.delete();
        bus_start();
        send_byte(8'hA8, ack);
        check("badaddr nack", 32'(ack), 1);
        check("badaddr busy", 32'(busy), 0);
        send_byte(8'h55, ack);
        check("badaddr byte_nack", 32'(ack), 1);
        bus_start();
        send_byte(8'h00, ack);
        check("gencall nack", 32'(ack), 1);
        bus_stop();
        check("badaddr no_we", we_q.size(), 0);
        check("badaddr no_re", re_q.size(), 0);

        do_write(8'h3F, 2, {16'h0, 8'($urandom), 8'($urandom)}, "wr_wrap");

        // Reset during the 4th bit of a read byte.
        bus_start();
        send_byte(8'hA6, ack);
        check("rstmid waddr_ack", 32'(ack), 0);
        send_byte(8'h10, ack);
        check("rstmid ptr_ack", 32'(ack), 0);
        bus_start();
        send_byte(8'hA7, ack);
        check("rstmid raddr_ack", 32'(ack), 0);
        for (int i = 0; i < 3; i++) recv_bit(b);
        sda_m = 1'b1; q_wait();
        scl_m = 1'b1; q_wait();
        check("rstmid oe_before", 32'(sda_oe), 1);
        reset_n = 1'b0;
        #1;
        check("rstmid oe_async", 32'(sda_oe), 0);
        check("rstmid busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        do_write(8'h31, 1, 32'h0B, "wr_after_rst");

        // STOP in the middle of a data byte.
        we_q.delete();
        bus_start();
        send_byte(8'hA6, ack);
        check("midstop addr_ack", 32'(ack), 0);
        send_byte(8'h20, ack);
        check("midstop ptr_ack", 32'(ack), 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        bus_stop();
        repeat (4) @(negedge clk);
        check("midstop no_we", we_q.size(), 0);
        check("midstop sda_oe", 32'(sda_oe), 0);
        check("midstop busy", 32'(busy), 0);
        send_byte(8'hA6, ack);
        check("midstop idle_ignores", 32'(ack), 1);

        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(8'($urandom), int'($urandom_range(1, 4)), $urandom, "rand_wr");
            else
                do_read(8'($urandom), int'($urandom_range(1, 4)), "rand_rd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
